// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared constants and per-channel state helpers for the button debouncer
//
// Contents:
//   DEBOUNCE_10MS_125MHZ : stable-cycle count giving 10 ms at a 125 MHz clock;
//                          top-level designs pass it as the DEBOUNCE parameter.
//   ch_state_e           : the four effective channel states, encoded as
//                          {level, synchronized input} so they can be read
//                          straight off the channel flops.
//   decode_state()       : maps level and synchronized input to ch_state_e.

package button_debouncer_pkg;

    localparam int DEBOUNCE_10MS_125MHZ = 1250000;

    // A PEND state is simply "synchronized input disagrees with level";
    // the counter only measures how long that disagreement has lasted.
    typedef enum logic [1:0] {
        CH_IDLE_LOW  = 2'b00,
        CH_PEND_HIGH = 2'b01,
        CH_PEND_LOW  = 2'b10,
        CH_IDLE_HIGH = 2'b11
    } ch_state_e;

    function automatic ch_state_e decode_state(input logic level, input logic s2);
        return ch_state_e'({level, s2});
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: 2-flop synchronizer, stability counter, level and strobes
//
// Parameters:
//   DEBOUNCE      : stable-cycle threshold in normal mode (>= 2)
//   TEST_DEBOUNCE : stable-cycle threshold when test_mode is high (2..DEBOUNCE)
// Ports:
//   clk           : sole clock, rising edge
//   rst           : synchronous active-high reset
//   in            : raw active-high button line, asynchronous to clk
//   test_mode     : selects TEST_DEBOUNCE instead of DEBOUNCE, quasi-static
//   level         : registered debounced level
//   press         : one-cycle strobe coinciding with the first high cycle of level
//   release_pulse : one-cycle strobe coinciding with the first low cycle of level

module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE      = DEBOUNCE_10MS_125MHZ,
    parameter int TEST_DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic test_mode,
    output logic level,
    output logic press,
    output logic release_pulse
);

    // The counter only ever has to hold T-1 <= DEBOUNCE-1, so clog2 bits suffice.
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] LIMIT_NORMAL = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LIMIT_TEST   = CNT_W'(TEST_DEBOUNCE - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    ch_state_e        state;
    logic [CNT_W-1:0] limit;
    logic             expired;

    // State register: synchronizer, counter, level and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Threshold select and expiry. The >= compare lets a switch to the
    // shorter threshold fire immediately when the count is already past it,
    // and because the count stops at the limit it can never wrap.
    always_comb begin
        limit   = test_mode ? LIMIT_TEST : LIMIT_NORMAL;
        expired = (cnt_q >= limit);
        state   = decode_state(level_q, s2_q);
    end

    // Next-state logic.
    always_comb begin
        s1_d    = in;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state)
            CH_IDLE_LOW, CH_IDLE_HIGH: begin
                // Input agrees with level: any partial count was bounce.
                cnt_d = '0;
            end
            CH_PEND_HIGH, CH_PEND_LOW: begin
                if (expired) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Strobe logic: computed alongside the toggle so the registered strobe
    // lands on the first cycle of the new level.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state)
            CH_PEND_HIGH: press_d   = expired;
            CH_PEND_LOW:  release_d = expired;
            default: begin
                press_d   = 1'b0;
                release_d = 1'b0;
            end
        endcase
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounces BUTTONS independent push-button lines into level and press/release strobes
//
// Parameters:
//   BUTTONS       : number of independent channels
//   DEBOUNCE      : stable-cycle threshold in normal mode (>= 2)
//   TEST_DEBOUNCE : stable-cycle threshold when test_mode is high (2..DEBOUNCE)
// Ports:
//   clk           : sole clock, rising edge
//   rst           : synchronous active-high reset
//   in            : raw active-high button lines, asynchronous to clk
//   test_mode     : selects TEST_DEBOUNCE for every channel, quasi-static
//   level         : registered debounced level per channel
//   press         : one-cycle strobe per channel when level rises
//   release_pulse : one-cycle strobe per channel when level falls

module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int BUTTONS       = 2,
    parameter int DEBOUNCE      = DEBOUNCE_10MS_125MHZ,
    parameter int TEST_DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BUTTONS-1:0] in,
    input  logic               test_mode,
    output logic [BUTTONS-1:0] level,
    output logic [BUTTONS-1:0] press,
    output logic [BUTTONS-1:0] release_pulse
);

    // Channels share only clk, rst and test_mode; nothing crosses between them.
    for (genvar i = 0; i < BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE      (DEBOUNCE),
            .TEST_DEBOUNCE (TEST_DEBOUNCE)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .in            (in[i]),
            .test_mode     (test_mode),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer with a behavioural reference model

module tb_button_debouncer;

    localparam int NB = 2;
    localparam int DB = 8;
    localparam int TDB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] in_r;
    logic          tmode;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;

    int checks = 0;
    int failures = 0;

    button_debouncer #(
        .BUTTONS       (NB),
        .DEBOUNCE      (DB),
        .TEST_DEBOUNCE (TDB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (in_r),
        .test_mode     (tmode),
        .level         (level),
        .press         (press),
        .release_pulse (rel)
    );

    always #5 clk = ~clk;

    // Reference model: the input seen by the filter is the raw input two
    // edges late; a channel's level flips once the filtered input has
    // disagreed with it for T consecutive edges, where T is whatever
    // threshold is selected on the flipping edge.
    logic [NB-1:0] m_d1, m_d2, m_level, m_press, m_rel;
    int            m_run [NB];
    bit            armed = 1'b0;

    always @(posedge clk) begin
        int t;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int c = 0; c < NB; c++) m_run[c] = 0;
            armed = 1'b1;
        end else begin
            t = tmode ? TDB : DB;
            for (int c = 0; c < NB; c++) begin
                m_press[c] = 1'b0;
                m_rel[c]   = 1'b0;
                if (m_d2[c] != m_level[c]) begin
                    if (m_run[c] + 1 >= t) begin
                        m_level[c] = m_d2[c];
                        m_press[c] = m_d2[c];
                        m_rel[c]   = ~m_d2[c];
                        m_run[c]   = 0;
                    end else begin
                        m_run[c]++;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = in_r;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ({level, press, rel} !== {m_level, m_press, m_rel}) begin
                failures++;
                $display("FAIL model_cmp t=%0t actual lvl=%b prs=%b rel=%b required lvl=%b prs=%b rel=%b",
                         $time, level, press, rel, m_level, m_press, m_rel);
            end
            checks++;
            if ((press & rel) !== '0) begin
                failures++;
                $display("FAIL strobe_excl t=%0t actual prs=%b rel=%b required no overlap", $time, press, rel);
            end
        end
    end

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
        end
    endtask

    // Strobe must stay low for n-1 sampled cycles and equal mask on the n-th.
    task automatic expect_strobe(input string nm, input int n, input logic [NB-1:0] mask, input bit is_rel);
        for (int i = 0; i < n - 1; i++) begin
            @(negedge clk);
            chk({nm, "_early"}, is_rel ? rel : press, '0);
        end
        @(negedge clk);
        chk(nm, is_rel ? rel : press, mask);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int runs [3] = '{1, 3, 7};
        rst = 1'b0; in_r = '0; tmode = 1'b0;

        // Reset with both buttons held.
        @(negedge clk);
        rst = 1'b1; in_r = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk("rst_level", level, 2'b00);
            chk("rst_press", press, 2'b00);
            chk("rst_rel", rel, 2'b00);
        end
        rst = 1'b0;
        expect_strobe("reset_press", 10, 2'b11, 1'b0);
        chk("reset_level", level, 2'b11);
        @(negedge clk);
        chk("reset_press_width", press, 2'b00);
        in_r = 2'b00;
        expect_strobe("settle_rel", 10, 2'b11, 1'b1);
        idle(3);

        // Clean press/release on ch0.
        in_r = 2'b01;
        expect_strobe("clean_press", 10, 2'b01, 1'b0);
        chk("clean_level", level, 2'b01);
        idle(3);
        in_r = 2'b00;
        expect_strobe("clean_rel", 10, 2'b01, 1'b1);
        chk("clean_level_low", level, 2'b00);
        idle(3);

        // Bounce: high runs of 1, 3, 7 separated by single lows, then hold.
        foreach (runs[r]) begin
            in_r = 2'b01;
            for (int i = 0; i < runs[r]; i++) begin
                @(negedge clk);
                chk("bounce_quiet", press | rel, 2'b00);
            end
            in_r = 2'b00;
            @(negedge clk);
            chk("bounce_quiet", press | rel, 2'b00);
        end
        in_r = 2'b01;
        expect_strobe("bounce_press", 10, 2'b01, 1'b0);
        in_r = 2'b00;
        expect_strobe("bounce_rel", 10, 2'b01, 1'b1);
        idle(3);

        // Test mode: fast threshold, short glitch rejected.
        tmode = 1'b1;
        idle(2);
        in_r = 2'b10;
        expect_strobe("tm_press", 5, 2'b10, 1'b0);
        idle(2);
        in_r = 2'b11;
        idle(2);
        in_r = 2'b10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("tm_glitch", press | rel, 2'b00);
        end
        chk("tm_glitch_level", level, 2'b10);
        in_r = 2'b00;
        expect_strobe("tm_rel", 5, 2'b10, 1'b1);
        idle(2);

        // Mode switch mid-count: count reaches 6, then fast threshold fires.
        tmode = 1'b0;
        idle(2);
        in_r = 2'b01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("switch_wait", press, 2'b00);
        end
        tmode = 1'b1;
        @(negedge clk);
        chk("mode_switch_press", press, 2'b01);
        in_r = 2'b00;
        expect_strobe("mode_switch_rel", 5, 2'b01, 1'b1);
        idle(2);
        tmode = 1'b0;
        idle(2);

        // Simultaneous press on both channels.
        in_r = 2'b11;
        expect_strobe("simul_press", 10, 2'b11, 1'b0);
        in_r = 2'b00;
        expect_strobe("simul_rel", 10, 2'b11, 1'b1);
        idle(3);

        // Reset mid-count: pending count discarded, restart from zero.
        in_r = 2'b01;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("pre_rst_quiet", press, 2'b00);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_press", press, 2'b00);
        chk("mid_rst_rel", rel, 2'b00);
        chk("mid_rst_level", level, 2'b00);
        rst = 1'b0;
        expect_strobe("post_rst_press", 10, 2'b01, 1'b0);
        chk("post_rst_level", level, 2'b01);

        // Random stimulus, checked only by the model compare.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) in_r[0] = ~in_r[0];
            if ($urandom_range(0, 5) == 0) in_r[1] = ~in_r[1];
            if ($urandom_range(0, 199) == 0) tmode = ~tmode;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
